rab_lookup_arbiter: RTL and testbench

N-port successor to the two-port RAB lookup decision FSM. Arbitrates round-robin between `NUM_PORTS` slave-port address requests, drives the winning port index to the shared TLB lookup, and registers the lookup verdict as a one-cycle accept/drop/miss pulse to the winning port plus interrupt pulses to the RAB config/IRQ logic. It then blocks new decisions until the winning port reports the transaction sent.

---
 rtl/rab_lookup_pkg.sv | 43 ++++
 rtl/rab_lookup_arbiter_if.sv | 50 +++++
 rtl/rab_rr_arbiter.sv | 50 +++++
 rtl/rab_lookup_arbiter.sv | 130 +++++++++++++
 tb/tb_rab_lookup_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rab_lookup_pkg.sv
// Shared types and the lookup decision rule for rab_lookup_arbiter.
// Optional feature macro: RAB_PREFETCH_EN (prefetch hits are dropped and
// raise int_prefetch when defined; otherwise prefetch_i is ignored).
package rab_lookup_pkg;

  typedef enum logic {
    ST_READY = 1'b0,
    ST_WAIT  = 1'b1
  } state_e;

  typedef struct packed {
    logic accept;
    logic drop;
    logic miss;
    logic int_miss;
    logic int_multi;
    logic int_prot;
    logic int_prefetch;
  } decision_t;

  // Verdict for one lookup result; accept and drop are always complementary.
  function automatic decision_t rab_decide(input logic no_hit, input logic multi_hit,
                                           input logic no_prot, input logic prefetch);
    decision_t d;
    logic      bad;
    bad = no_hit | multi_hit | ~no_prot;
`ifdef RAB_PREFETCH_EN
    bad            = bad | prefetch;
    d.int_prefetch = ~no_hit & prefetch;
`else
    // Prefetch plays no part in the verdict in this build.
    d.int_prefetch = prefetch & 1'b0;
`endif
    d.accept    = ~bad;
    d.drop      = bad;
    d.miss      = no_hit;
    d.int_miss  = no_hit;
    d.int_multi = multi_hit;
    d.int_prot  = ~no_prot;
    return d;
  endfunction

endpackage

// File: rtl/rab_lookup_arbiter_if.sv
// Port bundle of rab_lookup_arbiter. slave = arbiter side, master = the
// slave ports / TLB lookup / IRQ logic around it.
// Handshake: sel_valid_o high means a grant to sel_idx_o is made this cycle
// and the lookup result inputs must describe that port in the same cycle;
// the winner must later pulse sent_i[winner] before another grant is made.
interface rab_lookup_arbiter_if #(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ADDR_WIDTH = 40
);
  import rab_lookup_pkg::*;
  localparam int PORT_IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]      addr_valid_i;
  logic [NUM_PORTS-1:0]      sent_i;
  logic [PORT_IDX_W-1:0]     sel_idx_o;
  logic                      sel_valid_o;
  logic                      no_hit_i;
  logic                      multi_hit_i;
  logic                      no_prot_i;
  logic                      prefetch_i;
  logic [AXI_ADDR_WIDTH-1:0] out_addr_i;
  logic                      cache_coherent_i;
  logic [NUM_PORTS-1:0]      accept_o;
  logic [NUM_PORTS-1:0]      drop_o;
  logic [NUM_PORTS-1:0]      miss_o;
  logic [AXI_ADDR_WIDTH-1:0] out_addr_reg_o;
  logic                      cache_coherent_reg_o;
  logic                      int_miss_o;
  logic                      int_multi_o;
  logic                      int_prot_o;
  logic                      int_prefetch_o;
  logic [PORT_IDX_W-1:0]     int_port_o;
  state_e                    dbg_state_o;

  modport slave (
    input  addr_valid_i, sent_i, no_hit_i, multi_hit_i, no_prot_i, prefetch_i,
           out_addr_i, cache_coherent_i,
    output sel_idx_o, sel_valid_o, accept_o, drop_o, miss_o, out_addr_reg_o,
           cache_coherent_reg_o, int_miss_o, int_multi_o, int_prot_o,
           int_prefetch_o, int_port_o, dbg_state_o
  );

  modport master (
    output addr_valid_i, sent_i, no_hit_i, multi_hit_i, no_prot_i, prefetch_i,
           out_addr_i, cache_coherent_i,
    input  sel_idx_o, sel_valid_o, accept_o, drop_o, miss_o, out_addr_reg_o,
           cache_coherent_reg_o, int_miss_o, int_multi_o, int_prot_o,
           int_prefetch_o, int_port_o, dbg_state_o
  );
endinterface

// File: rtl/rab_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, wrapping at
// NUM_PORTS (also for non-power-of-two counts). Pointer advances past the
// pick when update_i is high and a pick exists.
module rab_rr_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 update_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 valid_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan the ports starting at the pointer and keep the first requester.
  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_PORTS)) cand = cand - (IDX_W+1)'(NUM_PORTS);
      cand_idx = cand[IDX_W-1:0];
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

  // Next pointer: one past the winner, wrapping from NUM_PORTS-1 to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (update_i && valid_o)
      ptr_d = (idx_o == IDX_W'(NUM_PORTS - 1)) ? '0 : idx_o + 1'b1;
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rab_lookup_arbiter.sv
// N-port RAB lookup arbiter: round-robin grant to the shared TLB lookup,
// registered one-cycle verdict pulses to the winner plus interrupt pulses,
// then WAIT until the winner reports its transaction sent.
// Optional feature macro: RAB_PREFETCH_EN (see rab_lookup_pkg).
module rab_lookup_arbiter
  import rab_lookup_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_ADDR_WIDTH = 40,
  parameter int PORT_IDX_W     = $clog2(NUM_PORTS)
) (
  input logic Clk_CI,
  input logic Rst_RI,
  rab_lookup_arbiter_if.slave bus
);

  state_e                    state_q, state_d;
  logic [PORT_IDX_W-1:0]     win_q, win_d;
  logic [NUM_PORTS-1:0]      accept_q, accept_d, drop_q, drop_d, miss_q, miss_d;
  logic                      int_miss_q, int_miss_d, int_multi_q, int_multi_d;
  logic                      int_prot_q, int_prot_d, int_pref_q, int_pref_d;
  logic [AXI_ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic                      cc_q, cc_d;
  logic [PORT_IDX_W-1:0]     int_port_q, int_port_d;
  logic [PORT_IDX_W-1:0]     grant_idx;
  logic                      grant_any;
  logic                      arb_update;
  logic                      sel_valid;
  decision_t                 dec;

  assign arb_update = (state_q == ST_READY);

  rab_rr_arbiter #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (PORT_IDX_W)
  ) u_rr (
    .clk     (Clk_CI),
    .rst     (Rst_RI),
    .req_i   (bus.addr_valid_i),
    .update_i(arb_update),
    .idx_o   (grant_idx),
    .valid_o (grant_any)
  );

  // FSM next state and the verdict that becomes next cycle's pulses.
  always_comb begin
    dec        = rab_decide(bus.no_hit_i, bus.multi_hit_i, bus.no_prot_i, bus.prefetch_i);
    sel_valid  = (state_q == ST_READY) && grant_any;
    state_d    = state_q;
    win_d      = win_q;
    accept_d   = '0;
    drop_d     = '0;
    miss_d     = '0;
    int_miss_d = 1'b0;
    int_multi_d = 1'b0;
    int_prot_d = 1'b0;
    int_pref_d = 1'b0;
    out_addr_d = out_addr_q;
    cc_d       = cc_q;
    int_port_d = int_port_q;
    case (state_q)
      ST_READY: begin
        if (sel_valid) begin
          accept_d[grant_idx] = dec.accept;
          drop_d[grant_idx]   = dec.drop;
          miss_d[grant_idx]   = dec.miss;
          int_miss_d  = dec.int_miss;
          int_multi_d = dec.int_multi;
          int_prot_d  = dec.int_prot;
          int_pref_d  = dec.int_prefetch;
          out_addr_d  = bus.out_addr_i;
          cc_d        = bus.cache_coherent_i;
          int_port_d  = grant_idx;
          win_d       = grant_idx;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Only the latched winner may release the lookup.
        if (bus.sent_i[win_q]) state_d = ST_READY;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= ST_READY;
      win_q       <= '0;
      accept_q    <= '0;
      drop_q      <= '0;
      miss_q      <= '0;
      int_miss_q  <= 1'b0;
      int_multi_q <= 1'b0;
      int_prot_q  <= 1'b0;
      int_pref_q  <= 1'b0;
      out_addr_q  <= '0;
      cc_q        <= 1'b0;
      int_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      accept_q    <= accept_d;
      drop_q      <= drop_d;
      miss_q      <= miss_d;
      int_miss_q  <= int_miss_d;
      int_multi_q <= int_multi_d;
      int_prot_q  <= int_prot_d;
      int_pref_q  <= int_pref_d;
      out_addr_q  <= out_addr_d;
      cc_q        <= cc_d;
      int_port_q  <= int_port_d;
    end
  end

  assign bus.sel_valid_o          = sel_valid;
  assign bus.sel_idx_o            = sel_valid ? grant_idx : '0;
  assign bus.accept_o             = accept_q;
  assign bus.drop_o               = drop_q;
  assign bus.miss_o               = miss_q;
  assign bus.int_miss_o           = int_miss_q;
  assign bus.int_multi_o          = int_multi_q;
  assign bus.int_prot_o           = int_prot_q;
  assign bus.int_prefetch_o       = int_pref_q;
  assign bus.out_addr_reg_o       = out_addr_q;
  assign bus.cache_coherent_reg_o = cc_q;
  assign bus.int_port_o           = int_port_q;
  assign bus.dbg_state_o          = state_q;

endmodule

// File: tb/tb_rab_lookup_arbiter.sv
// Bench for rab_lookup_arbiter: a 4-port instance for directed, table and
// randomized checks and a 3-port instance for round-robin fairness.
module tb_rab_lookup_arbiter;
  import rab_lookup_pkg::*;

  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int AW = 40;
`ifdef RAB_PREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  typedef struct {
    int       port;
    bit       nh, mh, np, pf;
    logic [3:0] acc, drop, miss, ints;  // ints = {miss, multi, prot, prefetch}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [63:0] exp_q[$];

  rab_lookup_arbiter_if #(.NUM_PORTS(N),  .AXI_ADDR_WIDTH(AW)) bus4 ();
  rab_lookup_arbiter_if #(.NUM_PORTS(N3), .AXI_ADDR_WIDTH(AW)) bus3 ();

  rab_lookup_arbiter #(.NUM_PORTS(N),  .AXI_ADDR_WIDTH(AW)) dut4 (.Clk_CI(clk), .Rst_RI(rst), .bus(bus4));
  rab_lookup_arbiter #(.NUM_PORTS(N3), .AXI_ADDR_WIDTH(AW)) dut3 (.Clk_CI(clk), .Rst_RI(rst), .bus(bus3));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_lookup(input bit nh, input bit mh, input bit np, input bit pf,
                            input logic [AW-1:0] addr, input bit cc);
    bus4.no_hit_i         = nh;
    bus4.multi_hit_i      = mh;
    bus4.no_prot_i        = np;
    bus4.prefetch_i       = pf;
    bus4.out_addr_i       = addr;
    bus4.cache_coherent_i = cc;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All registered outputs of the 4-port DUT in one word.
  function automatic logic [63:0] snap4();
    return {5'b0, bus4.accept_o, bus4.drop_o, bus4.miss_o,
            bus4.int_miss_o, bus4.int_multi_o, bus4.int_prot_o, bus4.int_prefetch_o,
            bus4.int_port_o, bus4.cache_coherent_reg_o, bus4.out_addr_reg_o};
  endfunction

  // ---------------- reference model ----------------
  // Verdict from the decision rules: returns {accept, drop, miss, ints}.
  function automatic logic [15:0] model_dec(input int port, input bit nh, input bit mh,
                                            input bit np, input bit pf);
    logic [3:0] oh;
    bit bad;
    oh  = 4'(1 << port);
    bad = nh || mh || !np || (PF_EN && pf);
    return {bad ? 4'b0 : oh, bad ? oh : 4'b0, nh ? oh : 4'b0,
            nh, mh, !np, PF_EN && !nh && pf};
  endfunction

  function automatic logic [63:0] pack_exp(input logic [15:0] dec, input int port,
                                           input bit cc, input logic [AW-1:0] addr);
    return {5'b0, dec, 2'(port), cc, addr};
  endfunction

  // ---------------- stimulus + checks ----------------
  initial begin
    vec_t vecs[7];
    logic [AW-1:0] a;
    int  m_ptr, m_win, m_port, g;
    bit  m_busy, m_cc, found;
    logic [AW-1:0] m_addr;
    logic [3:0] av, sn;
    bit nh, mh, np, pf, cc;

    vecs[0] = '{1, 1, 0, 1, 0, 4'b0000, 4'b0010, 4'b0010, 4'b1000};
    vecs[1] = '{0, 0, 0, 1, 0, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    vecs[2] = '{3, 0, 1, 1, 0, 4'b0000, 4'b1000, 4'b0000, 4'b0100};
    vecs[3] = '{2, 0, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 4'b0010};
`ifdef RAB_PREFETCH_EN
    vecs[4] = '{0, 0, 0, 1, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0001};
`else
    vecs[4] = '{0, 0, 0, 1, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
`endif
    vecs[5] = '{3, 1, 0, 1, 1, 4'b0000, 4'b1000, 4'b1000, 4'b1000};
    vecs[6] = '{2, 1, 1, 0, 0, 4'b0000, 4'b0100, 4'b0100, 4'b1110};

    bus4.addr_valid_i = '0; bus4.sent_i = '0;
    set_lookup(0, 0, 1, 0, '0, 0);
    bus3.addr_valid_i = '0; bus3.sent_i = '0;
    bus3.no_hit_i = 0; bus3.multi_hit_i = 0; bus3.no_prot_i = 1; bus3.prefetch_i = 0;
    bus3.out_addr_i = '0; bus3.cache_coherent_i = 0;

    // Reset then idle.
    rst = 1'b1;
    tick(); tick();
    mid();
    chk("reset_regs", snap4(), 64'h0);
    chk("reset_state", 64'(bus4.dbg_state_o), 64'(ST_READY));
    tick(); rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("idle_sel_valid", 64'(bus4.sel_valid_o), 64'h0);
      tick();
    end
    chk("idle_regs", snap4(), 64'h0);

    // Ports 0 and 2 valid, clean hits, sent one cycle after each pulse.
    bus4.addr_valid_i = 4'b0101;
    set_lookup(0, 0, 1, 0, 40'h12_3456_7000, 1);
    mid();
    chk("p02_grant0_valid", 64'(bus4.sel_valid_o), 64'h1);
    chk("p02_grant0_idx", 64'(bus4.sel_idx_o), 64'h0);
    tick();
    mid();
    chk("p02_accept0", 64'(bus4.accept_o), 64'h1);
    chk("p02_port0", 64'(bus4.int_port_o), 64'h0);
    chk("p02_addr0", 64'(bus4.out_addr_reg_o), 64'h12_3456_7000);
    chk("p02_cc0", 64'(bus4.cache_coherent_reg_o), 64'h1);
    chk("p02_wait_no_grant", 64'(bus4.sel_valid_o), 64'h0);
    tick(); bus4.sent_i = 4'b0001;
    mid();
    chk("p02_pulse_width", 64'(bus4.accept_o), 64'h0);
    chk("p02_wait_no_grant2", 64'(bus4.sel_valid_o), 64'h0);
    tick(); bus4.sent_i = '0;
    set_lookup(0, 0, 1, 0, 40'hAB_CDEF_0040, 0);
    mid();
    chk("p02_grant2_valid", 64'(bus4.sel_valid_o), 64'h1);
    chk("p02_grant2_idx", 64'(bus4.sel_idx_o), 64'h2);
    tick(); bus4.addr_valid_i = '0;
    mid();
    chk("p02_accept2", 64'(bus4.accept_o), 64'h4);
    chk("p02_port2", 64'(bus4.int_port_o), 64'h2);
    chk("p02_addr2", 64'(bus4.out_addr_reg_o), 64'hAB_CDEF_0040);
    tick(); bus4.sent_i = 4'b0100;
    tick(); bus4.sent_i = '0;

    // Table of single-port lookups; sent returned alongside the pulse.
    for (int k = 0; k < 7; k++) begin
      a = {8'(k), 32'($urandom)};
      bus4.addr_valid_i = 4'(1 << vecs[k].port);
      set_lookup(vecs[k].nh, vecs[k].mh, vecs[k].np, vecs[k].pf, a, 1'(k & 1));
      mid();
      chk("vec_sel_valid", 64'(bus4.sel_valid_o), 64'h1);
      chk("vec_sel_idx", 64'(bus4.sel_idx_o), 64'(vecs[k].port));
      tick();
      bus4.addr_valid_i = '0;
      bus4.sent_i = 4'(1 << vecs[k].port);
      mid();
      chk("vec_accept", 64'(bus4.accept_o), 64'(vecs[k].acc));
      chk("vec_drop", 64'(bus4.drop_o), 64'(vecs[k].drop));
      chk("vec_miss", 64'(bus4.miss_o), 64'(vecs[k].miss));
      chk("vec_ints", 64'({bus4.int_miss_o, bus4.int_multi_o, bus4.int_prot_o, bus4.int_prefetch_o}),
          64'(vecs[k].ints));
      chk("vec_int_port", 64'(bus4.int_port_o), 64'(vecs[k].port));
      chk("vec_addr", 64'(bus4.out_addr_reg_o), 64'(a));
      tick();
      bus4.sent_i = '0;
      mid();
      chk("vec_pulse_clear", 64'({bus4.accept_o, bus4.drop_o, bus4.miss_o, bus4.int_miss_o}), 64'h0);
      chk("vec_ready", 64'(bus4.dbg_state_o), 64'(ST_READY));
      tick();
    end

    // WAIT ignores sent from another port; no bypass on exit.
    bus4.addr_valid_i = 4'b0010;
    set_lookup(0, 0, 1, 0, 40'h1, 0);
    mid();
    chk("w_grant_idx", 64'(bus4.sel_idx_o), 64'h1);
    tick();
    mid();
    chk("w_no_grant", 64'(bus4.sel_valid_o), 64'h0);
    tick(); bus4.sent_i = 4'b0001;
    mid();
    chk("w_state_a", 64'(bus4.dbg_state_o), 64'(ST_WAIT));
    tick(); bus4.sent_i = '0;
    mid();
    chk("w_state_b", 64'(bus4.dbg_state_o), 64'(ST_WAIT));
    chk("w_no_grant_b", 64'(bus4.sel_valid_o), 64'h0);
    tick(); bus4.sent_i = 4'b0010;
    mid();
    chk("w_no_bypass", 64'(bus4.sel_valid_o), 64'h0);
    tick(); bus4.sent_i = '0;
    mid();
    chk("w_ready", 64'(bus4.dbg_state_o), 64'(ST_READY));
    chk("w_regrant", 64'(bus4.sel_valid_o), 64'h1);
    tick(); bus4.addr_valid_i = '0; bus4.sent_i = 4'b0010;
    tick(); bus4.sent_i = '0;

    // Reset in WAIT: pulses suppressed, late sent ignored, pointer back to 0.
    bus4.addr_valid_i = 4'b0100;
    set_lookup(1, 0, 1, 0, 40'hFF, 1);
    mid();
    chk("r_grant_idx", 64'(bus4.sel_idx_o), 64'h2);
    tick(); bus4.addr_valid_i = '0; rst = 1'b1;
    mid();
    chk("r_regs_zero", snap4(), 64'h0);
    chk("r_state", 64'(bus4.dbg_state_o), 64'(ST_READY));
    tick(); rst = 1'b0;
    tick(); bus4.sent_i = 4'b0100;
    mid();
    chk("r_late_sent_regs", snap4(), 64'h0);
    tick(); bus4.sent_i = '0;
    mid();
    chk("r_late_sent_state", 64'(bus4.dbg_state_o), 64'(ST_READY));
    tick(); bus4.addr_valid_i = 4'b1111;
    mid();
    chk("r_ptr_cleared", 64'(bus4.sel_idx_o), 64'h0);
    tick(); bus4.addr_valid_i = '0; bus4.sent_i = 4'b0001;
    tick(); bus4.sent_i = '0;

    // Fairness on the 3-port instance with every port requesting.
    bus3.addr_valid_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      found = 0;
      for (int w = 0; w < 8 && !found; w++) begin
        mid();
        if (bus3.sel_valid_o) found = 1;
        else tick();
      end
      chk("fair_grant_seen", 64'(found), 64'h1);
      if (found) begin
        chk("fair_order", 64'(bus3.sel_idx_o), 64'(k % N3));
        g = int'(bus3.sel_idx_o);
        tick(); bus3.sent_i = 3'(1 << g);
        tick(); bus3.sent_i = '0;
      end
    end
    bus3.addr_valid_i = '0;

    // Randomized traffic against the reference model.
    rst = 1'b1; bus4.addr_valid_i = '0; bus4.sent_i = '0;
    tick(); tick(); rst = 1'b0;
    m_ptr = 0; m_busy = 0; m_win = 0; m_port = 0; m_cc = 0; m_addr = '0;
    exp_q.push_back(64'h0);
    for (int c = 0; c < 400; c++) begin
      tick();
      av = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      sn = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'b0;
      nh = ($urandom_range(0, 3) == 0);
      mh = ($urandom_range(0, 7) == 0);
      np = ($urandom_range(0, 5) != 0);
      pf = ($urandom_range(0, 3) == 0);
      cc = 1'($urandom_range(0, 1));
      a  = {8'($urandom), 32'($urandom)};
      bus4.addr_valid_i = av;
      bus4.sent_i = sn;
      set_lookup(nh, mh, np, pf, a, cc);
      g = -1;
      if (!m_busy && av != 0)
        for (int i = 0; i < N; i++)
          if (g < 0 && av[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      mid();
      chk("rnd_sel_valid", 64'(bus4.sel_valid_o), 64'(g >= 0));
      chk("rnd_sel_idx", 64'(bus4.sel_idx_o), 64'(g >= 0 ? g : 0));
      chk("rnd_regs", snap4(), exp_q.pop_front());
      if (m_busy) begin
        if (sn[m_win]) m_busy = 0;
        exp_q.push_back(pack_exp(16'h0, m_port, m_cc, m_addr));
      end else if (g >= 0) begin
        m_busy = 1; m_win = g; m_ptr = (g + 1) % N;
        m_port = g; m_cc = cc; m_addr = a;
        exp_q.push_back(pack_exp(model_dec(g, nh, mh, np, pf), g, cc, a));
      end else begin
        exp_q.push_back(pack_exp(16'h0, m_port, m_cc, m_addr));
      end
    end

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
